// File: rtl/prbs_lock_checker_pkg.sv
// Shared PRBS definitions for the lock checker and the matching parallel generator.
// LFSR state convention: bit k holds the serial bit received k+1 steps ago.
package prbs_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  localparam int unsigned LFSR_MAX_W = 31;

  typedef struct packed {
    logic                  nbit;
    logic [LFSR_MAX_W-1:0] state;
  } prbs_step_t;

  // One serial step of b[n] = b[n-poly1] ^ b[n-poly2]; the new bit enters at bit 0.
  function automatic prbs_step_t prbs_step(input logic [LFSR_MAX_W-1:0] state,
                                           input int unsigned           poly1,
                                           input int unsigned           poly2);
    prbs_step_t            r;
    logic [LFSR_MAX_W-1:0] mask;
    logic [4:0]            idx1;
    logic [4:0]            idx2;
    idx1    = 5'(poly1 - 1);
    idx2    = 5'(poly2 - 1);
    mask    = {LFSR_MAX_W{1'b1}} >> (LFSR_MAX_W - poly2);
    r.nbit  = state[idx1] ^ state[idx2];
    r.state = ((state << 1) | LFSR_MAX_W'(r.nbit)) & mask;
    return r;
  endfunction

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + 6'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/prbs_lock_checker_if.sv
// Word stream, clear strobe and status/counter outputs of the PRBS lock checker.
interface prbs_lock_checker_if #(
  parameter int unsigned NBITS = 2,
  parameter int unsigned CNT_W = 32
);
  logic             in_valid;
  logic [NBITS-1:0] in_data;
  logic             clear;
  logic             locked;
  logic             error;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] word_cnt;

  modport master (
    output in_valid, in_data, clear,
    input  locked, error, err_cnt, word_cnt
  );

  modport slave (
    input  in_valid, in_data, clear,
    output locked, error, err_cnt, word_cnt
  );
endinterface

// File: rtl/prbs_lock_checker_lfsr_par.sv
// NBITS-step parallel Fibonacci LFSR with load; bits_o is the next word, bit 0 oldest.
module prbs_lfsr_par
  import prbs_pkg::*;
#(
  parameter int unsigned NBITS = 2,
  parameter int unsigned POLY1 = 6,
  parameter int unsigned POLY2 = 7
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             adv_i,
  input  logic             load_i,
  input  logic [POLY2-1:0] load_val_i,
  output logic [NBITS-1:0] bits_o
);

  logic [POLY2-1:0]      state_q;
  logic [POLY2-1:0]      state_d;
  logic [LFSR_MAX_W-1:0] walk;
  prbs_step_t            st;

  always_comb begin
    walk   = LFSR_MAX_W'(state_q);
    bits_o = '0;
    st     = '0;
    for (int i = 0; i < int'(NBITS); i++) begin
      st        = prbs_step(walk, POLY1, POLY2);
      bits_o[i] = st.nbit;
      walk      = st.state;
    end
    state_d = walk[POLY2-1:0];
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= '0;
    end else if (load_i) begin
      state_q <= load_val_i;
    end else if (adv_i) begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/prbs_lock_checker.sv
// Receive-side PRBS checker: self-synchronises on the received history, locks,
// then compares against a free-running local LFSR and counts bit errors.
module prbs_lock_checker
  import prbs_pkg::*;
#(
  parameter int unsigned NBITS    = 2,
  parameter int unsigned POLY1    = 6,
  parameter int unsigned POLY2    = 7,
  parameter int unsigned LOCK_CNT = 16,
  parameter int unsigned LOSS_CNT = 4,
  parameter int unsigned CNT_W    = 32
) (
  input logic                clk,
  input logic                resetn,
  prbs_lock_checker_if.slave bus
);

  localparam int unsigned RUN_W   = $clog2(LOCK_CNT + 1);
  localparam int unsigned LOSS_W  = $clog2(LOSS_CNT + 1);
  localparam logic [5:0]  BAD_THR = 6'(NBITS / 2);

  lock_state_e           state_q;
  logic [POLY2-1:0]      hist_q;
  logic [POLY2-1:0]      hist_upd;
  logic [RUN_W-1:0]      run_q;
  logic [LOSS_W-1:0]     loss_q;
  logic                  locked_q;
  logic                  error_q;
  logic [CNT_W-1:0]      err_cnt_q;
  logic [CNT_W-1:0]      err_cnt_d;
  logic [CNT_W-1:0]      word_cnt_q;
  logic [CNT_W-1:0]      word_cnt_d;
  logic [NBITS-1:0]      hunt_pred;
  logic [NBITS-1:0]      lfsr_pred;
  logic [NBITS-1:0]      mism;
  logic [5:0]            nerr;
  logic [LFSR_MAX_W-1:0] walk;
  prbs_step_t            st;
  logic                  clean;
  logic                  bad;
  logic                  lock_now;
  logic                  lfsr_adv;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [5:0]       inc);
    logic [CNT_W+5:0] sum;
    sum = {6'b0, a} + {{CNT_W{1'b0}}, inc};
    return (|sum[CNT_W+5:CNT_W]) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  // HUNT prediction: each received bit is shifted into the history before the next bit is predicted.
  always_comb begin
    walk      = LFSR_MAX_W'(hist_q);
    hunt_pred = '0;
    st        = '0;
    for (int i = 0; i < int'(NBITS); i++) begin
      st           = prbs_step(walk, POLY1, POLY2);
      hunt_pred[i] = st.nbit;
      walk         = st.state ^ LFSR_MAX_W'(st.nbit ^ bus.in_data[i]);
    end
    hist_upd = walk[POLY2-1:0];
  end

  assign mism     = ((state_q == LOCKED) ? lfsr_pred : hunt_pred) ^ bus.in_data;
  assign nerr     = popcount(32'(mism));
  assign clean    = (nerr == 6'd0) && (|hist_upd);
  assign bad      = nerr > BAD_THR;
  assign lock_now = bus.in_valid && (state_q == HUNT) && clean &&
                    (run_q == RUN_W'(LOCK_CNT - 1));
  assign lfsr_adv = bus.in_valid && (state_q == LOCKED);

  prbs_lfsr_par #(
    .NBITS (NBITS),
    .POLY1 (POLY1),
    .POLY2 (POLY2)
  ) u_lfsr (
    .clk        (clk),
    .rst_ni     (resetn),
    .adv_i      (lfsr_adv),
    .load_i     (lock_now),
    .load_val_i (hist_upd),
    .bits_o     (lfsr_pred)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= HUNT;
      hist_q   <= '0;
      run_q    <= '0;
      loss_q   <= '0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      error_q <= 1'b0;
      if (bus.in_valid) begin
        hist_q <= hist_upd;
        unique case (state_q)
          HUNT: begin
            if (lock_now) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
              run_q    <= '0;
              loss_q   <= '0;
            end else if (clean) begin
              run_q <= run_q + RUN_W'(1);
            end else begin
              run_q <= '0;
            end
          end
          LOCKED: begin
            error_q <= (nerr != 6'd0);
            if (!bad) begin
              loss_q <= '0;
            end else if (loss_q == LOSS_W'(LOSS_CNT - 1)) begin
              state_q  <= HUNT;
              locked_q <= 1'b0;
              loss_q   <= '0;
              run_q    <= '0;
            end else begin
              loss_q <= loss_q + LOSS_W'(1);
            end
          end
        endcase
      end
    end
  end

  // Counters keep their value across loss of lock; only clear or reset zero them.
  always_comb begin
    err_cnt_d  = err_cnt_q;
    word_cnt_d = word_cnt_q;
    if (bus.clear) begin
      err_cnt_d  = '0;
      word_cnt_d = '0;
    end else if (lfsr_adv) begin
      err_cnt_d  = sat_add(err_cnt_q, nerr);
      word_cnt_d = sat_add(word_cnt_q, 6'd1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      err_cnt_q  <= err_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign bus.locked   = locked_q;
  assign bus.error    = error_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.word_cnt = word_cnt_q;

endmodule

// File: tb/tb_prbs_lock_checker.sv
// Directed bench for prbs_lock_checker: PRBS7, NBITS=2, with a CNT_W=4 twin for saturation.
module tb_prbs_lock_checker;

  logic       clk = 1'b0;
  logic       resetn;
  logic       in_valid;
  logic [1:0] in_data;
  logic       clear;

  int n_cmp = 0;
  int n_bad = 0;
  int ptr   = 0;
  bit prbs [0:4095];

  prbs_lock_checker_if #(.NBITS(2), .CNT_W(32)) bus_a ();
  prbs_lock_checker_if #(.NBITS(2), .CNT_W(4))  bus_b ();

  assign bus_a.in_valid = in_valid;
  assign bus_a.in_data  = in_data;
  assign bus_a.clear    = clear;
  assign bus_b.in_valid = in_valid;
  assign bus_b.in_data  = in_data;
  assign bus_b.clear    = clear;

  prbs_lock_checker #(
    .NBITS(2), .POLY1(6), .POLY2(7), .LOCK_CNT(16), .LOSS_CNT(4), .CNT_W(32)
  ) dut_a (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_a)
  );

  prbs_lock_checker #(
    .NBITS(2), .POLY1(6), .POLY2(7), .LOCK_CNT(16), .LOSS_CNT(4), .CNT_W(4)
  ) dut_b (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_b)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic v, input logic [1:0] d, input logic c);
    in_valid = v;
    in_data  = d;
    clear    = c;
    @(posedge clk);
    #1;
  endtask

  // Next PRBS word (bit 0 oldest), optionally corrupted by flip.
  task automatic feed(input logic [1:0] flip, input logic c);
    logic [1:0] w;
    w   = {prbs[ptr+1], prbs[ptr]};
    ptr = ptr + 2;
    push(1'b1, w ^ flip, c);
  endtask

  initial begin
    int n;
    int nvalid;
    bit seen;

    // Window 1,0,0,0,0,0,1 makes only word 0 disagree with an all-zero history.
    prbs[0] = 1; prbs[1] = 0; prbs[2] = 0; prbs[3] = 0;
    prbs[4] = 0; prbs[5] = 0; prbs[6] = 1;
    for (int k = 7; k < 4096; k++) prbs[k] = prbs[k-6] ^ prbs[k-7];

    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = 2'b00;
    clear    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_locked",   32'(bus_a.locked),   0);
    check_eq("rst_error",    32'(bus_a.error),    0);
    check_eq("rst_err_cnt",  bus_a.err_cnt,       0);
    check_eq("rst_word_cnt", bus_a.word_cnt,      0);
    resetn = 1'b1;

    // All-zero stream must never lock.
    seen = 0;
    for (int k = 0; k < 500; k++) begin
      push(1'b1, 2'b00, 1'b0);
      if (bus_a.locked || bus_b.locked) seen = 1;
    end
    check_eq("zero_never_locked", 32'(seen), 0);
    check_eq("zero_err_cnt",  bus_a.err_cnt,  0);
    check_eq("zero_word_cnt", bus_a.word_cnt, 0);

    // Clean lock: 17 words from the first valid word.
    ptr = 0;
    n   = 0;
    while (!bus_a.locked && n < 40) begin
      feed(2'b00, 1'b0);
      n++;
    end
    check_eq("lock_latency",  n, 17);
    check_eq("b_locked",      32'(bus_b.locked), 1);
    check_eq("lock_word_cnt", bus_a.word_cnt, 0);

    feed(2'b00, 1'b0);
    check_eq("first_locked_word_cnt", bus_a.word_cnt, 1);
    seen = 0;
    for (int k = 0; k < 999; k++) begin
      feed(2'b00, 1'b0);
      if (bus_a.error) seen = 1;
    end
    check_eq("clean_no_error",  32'(seen), 0);
    check_eq("clean_err_cnt",   bus_a.err_cnt, 0);
    check_eq("clean_word_cnt",  bus_a.word_cnt, 1000);
    check_eq("b_word_cnt_sat",  32'(bus_b.word_cnt), 15);
    check_eq("b_clean_err_cnt", 32'(bus_b.err_cnt), 0);

    // Single-bit error.
    feed(2'b10, 1'b0);
    check_eq("sbe_error",   32'(bus_a.error),  1);
    check_eq("sbe_err_cnt", bus_a.err_cnt,     1);
    check_eq("sbe_locked",  32'(bus_a.locked), 1);
    feed(2'b00, 1'b0);
    check_eq("sbe_error_pulse", 32'(bus_a.error), 0);
    check_eq("sbe_err_hold",    bus_a.err_cnt,    1);
    check_eq("sbe_word_cnt",    bus_a.word_cnt,   1002);

    // Clear with a clean word, then four fully inverted words.
    feed(2'b00, 1'b1);
    check_eq("clr_err_cnt",  bus_a.err_cnt,  0);
    check_eq("clr_word_cnt", bus_a.word_cnt, 0);
    seen = 1;
    for (int k = 0; k < 3; k++) begin
      feed(2'b11, 1'b0);
      if (!bus_a.locked) seen = 0;
    end
    check_eq("loss_still_locked", 32'(seen), 1);
    feed(2'b11, 1'b0);
    check_eq("loss_locked",   32'(bus_a.locked), 0);
    check_eq("loss_err_cnt",  bus_a.err_cnt,     8);
    check_eq("loss_word_cnt", bus_a.word_cnt,    4);

    // Resumed word 3 straddles the inverted region, so relock needs words 4..19.
    n = 0;
    while (!bus_a.locked && n < 40) begin
      feed(2'b00, 1'b0);
      n++;
    end
    check_eq("relock_words",    n, 20);
    check_eq("hunt_word_hold",  bus_a.word_cnt, 4);
    check_eq("hunt_err_hold",   bus_a.err_cnt,  8);

    // Random stalls with garbage data on idle cycles.
    seen   = 0;
    nvalid = 0;
    for (int k = 0; k < 120; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        feed(2'b00, 1'b0);
        nvalid++;
      end else begin
        push(1'b0, 2'($urandom), 1'b0);
      end
      if (bus_a.error) seen = 1;
    end
    check_eq("stall_no_error",  32'(seen), 0);
    check_eq("stall_word_cnt",  bus_a.word_cnt, 32'(4 + nvalid));
    check_eq("stall_err_cnt",   bus_a.err_cnt,  8);
    check_eq("stall_locked",    32'(bus_a.locked), 1);

    // Clear wins over a simultaneous error word.
    feed(2'b10, 1'b1);
    check_eq("clrerr_err_cnt",  bus_a.err_cnt,  0);
    check_eq("clrerr_word_cnt", bus_a.word_cnt, 0);
    check_eq("clrerr_error",    32'(bus_a.error), 1);

    // Continuous single-bit errors: the 4-bit twin saturates.
    for (int k = 0; k < 20; k++) feed(2'b10, 1'b0);
    check_eq("b_err_sat",  32'(bus_b.err_cnt),  15);
    check_eq("b_word_sat", 32'(bus_b.word_cnt), 15);
    check_eq("b_sat_locked", 32'(bus_b.locked), 1);
    check_eq("a_err_20",   bus_a.err_cnt,  20);
    check_eq("a_word_20",  bus_a.word_cnt, 20);

    // Asynchronous reset between clock edges.
    in_valid = 1'b1;
    #3;
    resetn = 1'b0;
    #1;
    check_eq("arst_locked",   32'(bus_a.locked), 0);
    check_eq("arst_error",    32'(bus_a.error),  0);
    check_eq("arst_err_cnt",  bus_a.err_cnt,     0);
    check_eq("arst_word_cnt", bus_a.word_cnt,    0);
    check_eq("arst_b_err",    32'(bus_b.err_cnt), 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    ptr = 0;
    n   = 0;
    while (!bus_a.locked && n < 40) begin
      feed(2'b00, 1'b0);
      n++;
    end
    check_eq("reacquire_latency", n, 17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
